dlx_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the DLX instruction-fetch port (IF) and the data port (MEM).

---
 rtl/dlx_mem_pkg.sv | 30 +++
 rtl/dlx_mem_arbiter_if.sv | 26 ++
 rtl/dlx_mem_watchdog.sv | 35 +++
 rtl/dlx_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dlx_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared types and default widths for the DLX unified-memory arbiter slice.
package dlx_mem_pkg;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_MAX_D_STREAK = 4;
  localparam int DEF_TIMEOUT_CYC  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Which core port owns the access in flight for a given arbiter state
  function automatic port_e owner_of(input arb_state_e st);
    port_e p;
    case (st)
      BUSY_D:  p = PORT_D;
      default: p = PORT_I;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dlx_mem_arbiter_if.sv
// Single-ported memory bus between the arbiter (master) and the unified memory (slave).
interface dlx_mem_arbiter_if
  import dlx_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_rdata
  );

endinterface

// File: rtl/dlx_mem_watchdog.sv
// Counts cycles of an outstanding memory access and flags the one that must be abandoned.
module dlx_mem_watchdog
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic busy,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  logic [CW-1:0] count_r;

  // Elapsed busy cycles since the most recent grant
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= '0;
    end else if (busy) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Fires in the last permitted busy cycle; a zero limit disables it
  assign expire = (TIMEOUT_CYC > 0) && busy && (count_r == LAST);

endmodule

// File: rtl/dlx_mem_arbiter.sv
// DLX unified-memory arbiter: serialises IF and MEM accesses onto one single-ported
// memory and stalls the requesting pipeline stage until its access completes.
module dlx_mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_data_valid,
  output logic [DW-1:0] i_data_read,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_data_valid,
  output logic [DW-1:0] d_data_read,
  dlx_mem_arbiter_if.master mem,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          timeout_err
);

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e    state_r, state_s;
  logic          i_elig_s, d_elig_s, grant_i_s, grant_d_s, done_s, expire_s, busy_s;
  logic          m_req_r, m_we_r;
  logic [AW-1:0] m_addr_r;
  logic [DW-1:0] m_wdata_r;
  logic          i_data_valid_r, d_data_valid_r, timeout_err_r;
  logic [DW-1:0] i_data_read_r, d_data_read_r;
  logic [SW-1:0] streak_r;

  // A port is ignored while its completion pulse is out so a still-held request is not re-served
  assign i_elig_s = i_req & ~i_data_valid_r;
  assign d_elig_s = d_req & ~d_data_valid_r;
  assign busy_s   = (state_r != IDLE);

  dlx_mem_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grant_i_s | grant_d_s),
    .busy    (busy_s),
    .expire  (expire_s)
  );

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant selection and completion detection
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_elig_s && !(i_elig_s && (streak_r == STREAK_MAX))) begin
          grant_d_s = 1'b1;
          state_s   = BUSY_D;
        end else if (i_elig_s) begin
          grant_i_s = 1'b1;
          state_s   = BUSY_I;
        end else begin
          state_s   = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem.m_ack || expire_s) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Memory request payload and core response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_req_r        <= 1'b0;
      m_we_r         <= 1'b0;
      m_addr_r       <= '0;
      m_wdata_r      <= '0;
      i_data_valid_r <= 1'b0;
      d_data_valid_r <= 1'b0;
      i_data_read_r  <= '0;
      d_data_read_r  <= '0;
      timeout_err_r  <= 1'b0;
    end else begin
      i_data_valid_r <= 1'b0;
      d_data_valid_r <= 1'b0;
      if (grant_d_s) begin
        m_req_r   <= 1'b1;
        m_we_r    <= d_we;
        m_addr_r  <= d_addr;
        m_wdata_r <= d_wdata;
      end else if (grant_i_s) begin
        m_req_r   <= 1'b1;
        m_we_r    <= 1'b0;
        m_addr_r  <= i_addr;
        m_wdata_r <= '0;
      end else if (done_s) begin
        m_req_r <= 1'b0;
        m_we_r  <= 1'b0;
        // An expired access still completes, with zero data, so the pipeline never hangs
        if (owner_of(state_r) == PORT_I) begin
          i_data_valid_r <= 1'b1;
          i_data_read_r  <= mem.m_ack ? mem.m_rdata : '0;
        end else begin
          d_data_valid_r <= 1'b1;
          d_data_read_r  <= (mem.m_ack && !m_we_r) ? mem.m_rdata : '0;
        end
        if (!mem.m_ack) begin
          timeout_err_r <= 1'b1;
        end
      end
    end
  end

  // Consecutive data grants while a fetch is waiting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      streak_r <= '0;
    end else if (!i_req || grant_i_s) begin
      streak_r <= '0;
    end else if (grant_d_s && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + SW'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

  assign mem.m_req    = m_req_r;
  assign mem.m_we     = m_we_r;
  assign mem.m_addr   = m_addr_r;
  assign mem.m_wdata  = m_wdata_r;
  assign i_data_valid = i_data_valid_r;
  assign i_data_read  = i_data_read_r;
  assign d_data_valid = d_data_valid_r;
  assign d_data_read  = d_data_read_r;
  assign timeout_err  = timeout_err_r;
  assign stall_if     = i_req & ~i_data_valid_r;
  assign stall_mem    = d_req & ~d_data_valid_r;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Self-checking bench for dlx_mem_arbiter: vector table plus corner-case sequences,
// with a behavioural memory and a response scoreboard per core port.
module tb_dlx_mem_arbiter;
  import dlx_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 8;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_data_valid;
  logic [DW-1:0] i_data_read;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_data_valid;
  logic [DW-1:0] d_data_read;
  logic          stall_if, stall_mem, timeout_err;

  dlx_mem_arbiter_if #(.AW(AW), .DW(DW)) mif ();

  dlx_mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_data_valid(i_data_valid), .i_data_read(i_data_read),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data_valid(d_data_valid), .d_data_read(d_data_read),
    .mem(mif),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stall_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory model: acks ack_after cycles after m_req rises; logs every grant
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          c;
  } gnt_t;
  gnt_t        gq[$];
  int          ack_after = 0;
  logic [31:0] mem_rdata_cfg = '0;
  bit          mem_en = 1'b1;
  bit          addr_data = 1'b0;
  bit          stray = 1'b0;

  initial begin
    int   cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    mif.m_ack = 1'b0;
    mif.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mif.m_ack = 1'b0;
      mif.m_rdata = 32'hBAD0_BAD0;
      if (mif.m_req && !prev) gq.push_back('{mif.m_we, mif.m_addr, mif.m_wdata, cyc});
      prev = mif.m_req;
      if (stray) begin
        mif.m_ack = 1'b1;
        mif.m_rdata = 32'h5757_5757;
        stray = 1'b0;
      end else if (mem_en && mif.m_req) begin
        if (cnt == ack_after) begin
          mif.m_ack = 1'b1;
          mif.m_rdata = addr_data ? (mif.m_addr ^ KEY) : mem_rdata_cfg;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: pop the expected word for a port whenever it pulses valid
  logic [31:0] exp_iq[$];
  logic [31:0] exp_dq[$];
  int i_valid_cyc = 0, d_valid_cyc = 0, n_ivalid = 0, n_dvalid = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (i_data_valid) begin
        n_ivalid++;
        i_valid_cyc = cyc;
        if (exp_iq.size() == 0) begin
          n_chk++;
          $display("FAIL i_unexpected_valid: got data 0x%08h, expected no pulse", i_data_read);
        end else chk("i_data_read", i_data_read, exp_iq.pop_front());
      end
      if (d_data_valid) begin
        n_dvalid++;
        d_valid_cyc = cyc;
        if (exp_dq.size() == 0) begin
          n_chk++;
          $display("FAIL d_unexpected_valid: got data 0x%08h, expected no pulse", d_data_read);
        end else chk("d_data_read", d_data_read, exp_dq.pop_front());
      end
    end
  end

  task automatic do_if(input logic [31:0] addr, input logic [31:0] exp, output int lat);
    exp_iq.push_back(exp);
    i_req = 1'b1;
    i_addr = addr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!i_data_valid && !stall_if) stall_bad++;
    end while (!i_data_valid && lat < 200);
    if (!i_data_valid) begin
      n_chk++;
      $display("FAIL if_wait: no i_data_valid after %0d cycles, addr 0x%08h", lat, addr);
      exp_iq.delete();
    end
    if (stall_if) stall_bad++;
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input bit hold, output int lat);
    exp_dq.push_back(exp);
    d_req = 1'b1;
    d_we = we;
    d_addr = addr;
    d_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!d_data_valid && !stall_mem) stall_bad++;
    end while (!d_data_valid && lat < 200);
    if (!d_data_valid) begin
      n_chk++;
      $display("FAIL d_wait: no d_data_valid after %0d cycles, addr 0x%08h", lat, addr);
      exp_dq.delete();
    end
    if (stall_mem) stall_bad++;
    if (!hold) d_req = 1'b0;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_after;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t tv[6];
    gnt_t g, g1;
    int   lat, lat_d, lat_i, pos, n_if, nv;

    tv[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 2, 32'hA5A5_0001, 32'hA5A5_0001, 4};
    tv[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 0, 32'h1357_9BDF, 32'h1357_9BDF, 2};
    tv[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'hDEAD_BEEF, 32'h0000_0000, 3};
    tv[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7};
    tv[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 2};
    tv[5] = '{1'b1, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 3, 32'hCAFE_F00D, 32'h0000_0000, 5};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", mif.m_req, 32'd0);
    chk("rst_m_we", mif.m_we, 32'd0);
    chk("rst_m_addr", mif.m_addr, 32'd0);
    chk("rst_m_wdata", mif.m_wdata, 32'd0);
    chk("rst_i_valid", i_data_valid, 32'd0);
    chk("rst_d_valid", d_data_valid, 32'd0);
    chk("rst_i_read", i_data_read, 32'd0);
    chk("rst_d_read", d_data_read, 32'd0);
    chk("rst_timeout_err", timeout_err, 32'd0);
    chk("rst_stall_if", stall_if, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single transactions from the vector table
    for (int k = 0; k < 6; k++) begin
      ack_after = tv[k].ack_after;
      mem_rdata_cfg = tv[k].rdata;
      stall_bad = 0;
      if (tv[k].is_d) do_d(tv[k].we, tv[k].addr, tv[k].wdata, tv[k].exp_data, 1'b0, lat);
      else do_if(tv[k].addr, tv[k].exp_data, lat);
      chk($sformatf("v%0d_latency", k), lat, tv[k].exp_lat);
      chk($sformatf("v%0d_stall", k), stall_bad, 32'd0);
      if (gq.size() != 1) begin
        n_chk++;
        $display("FAIL v%0d_grants: got %0d grants, expected 1", k, gq.size());
        gq.delete();
      end else begin
        g = gq.pop_front();
        chk($sformatf("v%0d_m_we", k), g.we, tv[k].is_d & tv[k].we);
        chk($sformatf("v%0d_m_addr", k), g.addr, tv[k].addr);
        if (tv[k].we) chk($sformatf("v%0d_m_wdata", k), g.wdata, tv[k].wdata);
      end
      @(negedge clk);
    end

    // Simultaneous requests: data first, fetch m_req one cycle after d_data_valid
    ack_after = 0;
    addr_data = 1'b1;
    fork
      do_d(1'b0, 32'h0000_0200, 32'h0, 32'h0000_0200 ^ KEY, 1'b0, lat_d);
      do_if(32'h0000_0300, 32'h0000_0300 ^ KEY, lat_i);
    join
    chk("t2_d_latency", lat_d, 32'd2);
    chk("t2_i_latency", lat_i, 32'd4);
    if (gq.size() != 2) begin
      n_chk++;
      $display("FAIL t2_grants: got %0d grants, expected 2", gq.size());
    end else begin
      g = gq.pop_front();
      g1 = gq.pop_front();
      chk("t2_first_grant_addr", g.addr, 32'h0000_0200);
      chk("t2_second_grant_addr", g1.addr, 32'h0000_0300);
      chk("t2_if_mreq_cycle", g1.c, d_valid_cyc + 1);
    end
    gq.delete();
    @(negedge clk);

    // Data held continuously with a fetch pending: fetch gets in within the streak limit
    fork
      begin
        int lx;
        for (int j = 0; j < 6; j++) begin
          logic [31:0] a;
          a = 32'h0000_1000 + 32'(j) * 32'd4;
          do_d(1'b0, a, 32'h0, a ^ KEY, (j < 5), lx);
        end
      end
      begin
        int ly;
        do_if(32'h0000_2000, 32'h0000_2000 ^ KEY, ly);
      end
    join
    chk("t4_grant_count", gq.size(), 32'd7);
    pos = -1;
    n_if = 0;
    foreach (gq[q]) begin
      if (gq[q].addr == 32'h0000_2000) begin
        n_if++;
        if (pos < 0) pos = q;
      end
    end
    chk("t4_if_grants", n_if, 32'd1);
    chk("t4_if_within_streak", (pos >= 1 && pos <= MAXS), 32'd1);
    if (gq.size() > 0) chk("t4_last_grant_addr", gq[gq.size() - 1].addr, 32'h0000_1014);
    gq.delete();
    @(negedge clk);

    // Watchdog: no ack, zero-data completion after TO busy cycles, then normal service
    mem_en = 1'b0;
    do_d(1'b0, 32'h0000_0080, 32'h0, 32'h0, 1'b0, lat);
    chk("t5_timeout_latency", lat, 32'(TO + 1));
    chk("t5_timeout_err", timeout_err, 32'd1);
    chk("t5_m_req_dropped", mif.m_req, 32'd0);
    gq.delete();
    mem_en = 1'b1;
    ack_after = 1;
    @(negedge clk);
    do_if(32'h0000_0044, 32'h0000_0044 ^ KEY, lat);
    chk("t5_after_latency", lat, 32'd3);
    chk("t5_err_sticky", timeout_err, 32'd1);
    gq.delete();
    @(negedge clk);

    // Reset during BUSY_D abandons the access; a stray ack later is ignored
    mem_en = 1'b0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h0000_0300;
    repeat (2) @(negedge clk);
    chk("t6_busy_m_req", mif.m_req, 32'd1);
    reset_n = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk("t6_rst_m_req", mif.m_req, 32'd0);
    chk("t6_rst_state", dut.state_r, 32'(IDLE));
    chk("t6_rst_err", timeout_err, 32'd0);
    reset_n = 1'b1;
    mem_en = 1'b1;
    gq.delete();
    nv = n_ivalid + n_dvalid;
    stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_stray_ack_pulses", n_ivalid + n_dvalid - nv, 32'd0);
    chk("t6_stray_no_grant", gq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench still running at time %0t, expected completion", $time);
    $fatal(1, "time limit");
  end

endmodule
